pll_reconfig_sequencer: RTL and testbench

Sequences a complete PLL frequency change through the ALTPLLRECONFIG megafunction. Accepts one request carrying the N, M and C divider values, then:
- converts each divider into high-count, low-count, bypass and odd parameters;
- writes the parameters one at a time, honouring `busy`;
- issues the reconfig pulse;
- waits for the PLL to relock, retrying on timeout.

It sits between the DDS frequency-plan logic and the ALTPLLRECONFIG instance driving the DDS PLL.

---
 rtl/pll_reconfig_pkg.sv | 48 ++++
 rtl/lock_sync.sv | 23 ++
 rtl/pll_reconfig_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_pll_reconfig_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_reconfig_pkg.sv
// rtl/pll_reconfig_pkg.sv - shared codes, states and divider helper for the PLL reconfig sequencer
//
// Holds the ALTPLLRECONFIG counter_type / counter_param encodings, the
// sequencer state enumeration and div_to_params(), which splits one divider
// into the four values written for a counter.
package pll_reconfig_pkg;

    localparam logic [3:0] CT_N      = 4'd0;
    localparam logic [3:0] CT_M      = 4'd1;
    localparam logic [3:0] CT_C_BASE = 4'd4;

    localparam logic [2:0] CP_HIGH   = 3'd0;
    localparam logic [2:0] CP_LOW    = 3'd1;
    localparam logic [2:0] CP_BYPASS = 3'd4;
    localparam logic [2:0] CP_ODD    = 3'd5;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHECK,
        S_WRITE,
        S_WGAP,
        S_WWAIT,
        S_RECONF,
        S_RGAP,
        S_RWAIT,
        S_LOCK,
        S_DONE,
        S_ERROR
    } state_t;

    typedef struct packed {
        logic [8:0] high;
        logic [8:0] low;
        logic [8:0] bypass;
        logic [8:0] odd;
    } div_params_t;

    // high = ceil(d/2), low = floor(d/2); bypass still carries real high/low.
    function automatic div_params_t div_to_params(input logic [7:0] d);
        div_params_t p;
        p.low    = {2'b00, d[7:1]};
        p.high   = p.low + {8'd0, d[0]};
        p.bypass = {8'd0, (d == 8'd1)};
        p.odd    = {8'd0, d[0]};
        return p;
    endfunction

endpackage

// File: rtl/lock_sync.sv
// rtl/lock_sync.sv - two-flop synchronizer for the asynchronous PLL locked signal
//
// Ports: clk, reset_n (async active-low), d (async input), q (synchronized, resets to 0).
module lock_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reconfig_sequencer.sv
// rtl/pll_reconfig_sequencer.sv - sequences a full N/M/C divider change through ALTPLLRECONFIG
//
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   req_valid/req_ready          request handshake (ready only in IDLE)
//   n_div, m_div, c_div          dividers, latched at the transfer (C0 in c_div[7:0])
//   write_param, reconfig        one-cycle strobes to ALTPLLRECONFIG
//   counter_type, counter_param, data_in   parameter address/value, held outside WRITE
//   busy                         ALTPLLRECONFIG busy
//   locked                       PLL lock, asynchronous
//   done, error                  one-cycle result pulses
//   active                       sequence in progress
module pll_reconfig_sequencer
    import pll_reconfig_pkg::*;
#(
    parameter int NUM_C        = 2,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int MAX_RETRY    = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [7:0]         n_div,
    input  logic [7:0]         m_div,
    input  logic [8*NUM_C-1:0] c_div,
    output logic               write_param,
    output logic               reconfig,
    output logic [3:0]         counter_type,
    output logic [2:0]         counter_param,
    output logic [8:0]         data_in,
    input  logic               busy,
    input  logic               locked,
    output logic               done,
    output logic               error,
    output logic               active
);

    localparam int         TW       = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [2:0] LAST_CTR = 3'(NUM_C + 1);

    state_t             state, state_next;
    logic [7:0]         n_q, m_q;
    logic [8*NUM_C-1:0] c_q;
    logic [2:0]         ctr_idx, ctr_next;
    logic [1:0]         par_idx, par_next;
    logic [TW-1:0]      lock_cnt, lock_cnt_next;
    logic [7:0]         retry_cnt, retry_next;
    logic               locked_s;
    logic               invalid;
    logic [7:0]         sel_div;
    div_params_t        sel_p;
    logic [3:0]         sel_type;
    logic [2:0]         sel_param;
    logic [8:0]         sel_data;

    lock_sync u_lock_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (locked),
        .q       (locked_s)
    );

    always_comb begin
        invalid = (n_q == 8'd0) || (m_q == 8'd0);
        for (int i = 0; i < NUM_C; i++) begin
            if (c_q[8*i +: 8] == 8'd0) invalid = 1'b1;
        end
    end

    // Parameter for the position being entered, so the output registers can
    // be loaded on the same edge that moves the FSM into WRITE.
    always_comb begin
        sel_div   = n_q;
        sel_type  = CT_N;
        sel_param = CP_HIGH;
        sel_data  = '0;
        if (ctr_next == 3'd1) begin
            sel_div  = m_q;
            sel_type = CT_M;
        end
        for (int i = 0; i < NUM_C; i++) begin
            if (ctr_next == 3'(i + 2)) begin
                sel_div  = c_q[8*i +: 8];
                sel_type = CT_C_BASE + 4'(i);
            end
        end
        sel_p = div_to_params(sel_div);
        case (par_next)
            2'd0:    begin sel_param = CP_HIGH;   sel_data = sel_p.high;   end
            2'd1:    begin sel_param = CP_LOW;    sel_data = sel_p.low;    end
            2'd2:    begin sel_param = CP_BYPASS; sel_data = sel_p.bypass; end
            default: begin sel_param = CP_ODD;    sel_data = sel_p.odd;    end
        endcase
    end

    always_comb begin
        state_next    = state;
        ctr_next      = ctr_idx;
        par_next      = par_idx;
        lock_cnt_next = lock_cnt;
        retry_next    = retry_cnt;
        case (state)
            S_IDLE:   if (req_valid) state_next = S_CHECK;
            S_CHECK: begin
                ctr_next   = 3'd0;
                par_next   = 2'd0;
                retry_next = 8'd0;
                state_next = invalid ? S_ERROR : S_WRITE;
            end
            S_WRITE:  state_next = S_WGAP;
            S_WGAP:   state_next = S_WWAIT;
            S_WWAIT: begin
                if (!busy) begin
                    if (ctr_idx == LAST_CTR && par_idx == 2'd3) begin
                        state_next = S_RECONF;
                    end else begin
                        state_next = S_WRITE;
                        if (par_idx == 2'd3) begin
                            par_next = 2'd0;
                            ctr_next = ctr_idx + 3'd1;
                        end else begin
                            par_next = par_idx + 2'd1;
                        end
                    end
                end
            end
            S_RECONF: state_next = S_RGAP;
            S_RGAP:   state_next = S_RWAIT;
            S_RWAIT: begin
                if (!busy) begin
                    state_next    = S_LOCK;
                    lock_cnt_next = '0;
                end
            end
            S_LOCK: begin
                if (locked_s) begin
                    state_next = S_DONE;
                end else if (lock_cnt == TW'(LOCK_TIMEOUT)) begin
                    if (retry_cnt < 8'(MAX_RETRY)) begin
                        retry_next = retry_cnt + 8'd1;
                        ctr_next   = 3'd0;
                        par_next   = 2'd0;
                        state_next = S_WRITE;
                    end else begin
                        state_next = S_ERROR;
                    end
                end else begin
                    lock_cnt_next = lock_cnt + TW'(1);
                end
            end
            S_DONE:   state_next = S_IDLE;
            S_ERROR:  state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            ctr_idx       <= '0;
            par_idx       <= '0;
            lock_cnt      <= '0;
            retry_cnt     <= '0;
            n_q           <= '0;
            m_q           <= '0;
            c_q           <= '0;
            req_ready     <= 1'b1;
            write_param   <= 1'b0;
            reconfig      <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            active        <= 1'b0;
            counter_type  <= '0;
            counter_param <= '0;
            data_in       <= '0;
        end else begin
            state     <= state_next;
            ctr_idx   <= ctr_next;
            par_idx   <= par_next;
            lock_cnt  <= lock_cnt_next;
            retry_cnt <= retry_next;
            if (state == S_IDLE && req_valid) begin
                n_q <= n_div;
                m_q <= m_div;
                c_q <= c_div;
            end
            req_ready   <= (state_next == S_IDLE);
            write_param <= (state_next == S_WRITE);
            reconfig    <= (state_next == S_RECONF);
            done        <= (state_next == S_DONE);
            error       <= (state_next == S_ERROR);
            active      <= (state_next != S_IDLE);
            if (state_next == S_WRITE) begin
                counter_type  <= sel_type;
                counter_param <= sel_param;
                data_in       <= sel_data;
            end
        end
    end

endmodule

// File: tb/tb_pll_reconfig_sequencer.sv
// tb/tb_pll_reconfig_sequencer.sv - scoreboard bench for pll_reconfig_sequencer
module tb_pll_reconfig_sequencer;

    localparam int NUM_C        = 2;
    localparam int LOCK_TIMEOUT = 100;
    localparam int MAX_RETRY    = 3;

    logic        clk = 1'b0;
    logic        reset_n, req_valid, req_ready;
    logic [7:0]  n_div, m_div;
    logic [15:0] c_div;
    logic        write_param, reconfig;
    logic [3:0]  counter_type;
    logic [2:0]  counter_param;
    logic [8:0]  data_in;
    logic        busy, locked, done, error, active;

    pll_reconfig_sequencer #(
        .NUM_C        (NUM_C),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .MAX_RETRY    (MAX_RETRY)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .n_div         (n_div),
        .m_div         (m_div),
        .c_div         (c_div),
        .write_param   (write_param),
        .reconfig      (reconfig),
        .counter_type  (counter_type),
        .counter_param (counter_param),
        .data_in       (data_in),
        .busy          (busy),
        .locked        (locked),
        .done          (done),
        .error         (error),
        .active        (active)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_q[$];
    int          wr_seen = 0, rc_seen = 0, done_seen = 0, err_seen = 0;
    int          xfer_cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitor: pops the scoreboard on every parameter write.
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (write_param) begin
                wr_seen++;
                if (exp_q.size() == 0) begin
                    check("wr_extra", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_word", 32'({counter_type, counter_param, data_in}), 32'(e));
                end
            end
            if (reconfig) rc_seen++;
            if (done)     done_seen++;
            if (error)    err_seen++;
            if (done || error) check("done_err_excl", 32'(done & error), 32'd0);
        end
    end

    // Busy model: 4 cycles after each strobe, 200 after the chosen write.
    int bm_writes = 0, stretch_target = -1, busy_left = 0, fall_cyc = 0;
    initial begin
        busy = 1'b0;
        forever begin
            @(negedge clk);
            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) begin
                    busy     = 1'b0;
                    fall_cyc = cyc;
                end
            end else if (write_param || reconfig) begin
                if (write_param) bm_writes++;
                busy      = 1'b1;
                busy_left = (write_param && bm_writes == stretch_target) ? 200 : 4;
            end
        end
    end

    // Lock model: drops at reconfig, relocks 50 cycles later when enabled.
    int bm_rc = 0, lock_target = -1, lock_at = -1;
    bit lock_every = 1'b0;
    initial begin
        locked = 1'b0;
        forever begin
            @(negedge clk);
            if (reconfig) begin
                bm_rc++;
                locked  = 1'b0;
                lock_at = (lock_every || bm_rc == lock_target) ? cyc + 50 : -1;
            end else if (cyc == lock_at) begin
                locked = 1'b1;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] n, input logic [7:0] m,
                            input logic [7:0] c0, input logic [7:0] c1);
        int         di;
        logic [3:0] t;
        logic [2:0] p;
        logic [8:0] v;
        for (int k = 0; k < 4; k++) begin
            case (k)
                0:       di = int'(n);
                1:       di = int'(m);
                2:       di = int'(c0);
                default: di = int'(c1);
            endcase
            t = (k < 2) ? 4'(k) : 4'(k + 2);
            for (int j = 0; j < 4; j++) begin
                case (j)
                    0:       begin p = 3'd0; v = 9'((di + 1) / 2); end
                    1:       begin p = 3'd1; v = 9'(di / 2);       end
                    2:       begin p = 3'd4; v = 9'(di == 1);      end
                    default: begin p = 3'd5; v = 9'(di % 2);       end
                endcase
                exp_q.push_back({t, p, v});
            end
        end
    endtask

    // Presents a request, completes the handshake, then applies the
    // after-transfer divider values (and optionally keeps req_valid high).
    task automatic send_req(input logic [7:0] n, input logic [7:0] m,
                            input logic [7:0] c0, input logic [7:0] c1,
                            input int attempts, input bit keep_valid,
                            input logic [7:0] an, input logic [7:0] am,
                            input logic [7:0] ac0, input logic [7:0] ac1);
        n_div     = n;
        m_div     = m;
        c_div     = {c1, c0};
        req_valid = 1'b1;
        for (int i = 0; i < 400 && !req_ready; i++) tick();
        check("req_ready_wait", 32'(req_ready), 32'd1);
        for (int a = 0; a < attempts; a++) push_exp(n, m, c0, c1);
        xfer_cyc = cyc;
        @(posedge clk);
        #1;
        req_valid = keep_valid;
        n_div     = an;
        m_div     = am;
        c_div     = {ac1, ac0};
    endtask

    task automatic wait_end(input int base, input int limit);
        for (int i = 0; i < limit && (done_seen + err_seen) == base; i++) tick();
    endtask

    int bw, br, bd, be, t3;

    task automatic snap();
        bw = wr_seen; br = rc_seen; bd = done_seen; be = err_seen;
    endtask

    task automatic check_counts(input string tag, input int w, input int r, input int d, input int e);
        check({tag, "_writes"}, 32'(wr_seen - bw), 32'(w));
        check({tag, "_reconf"}, 32'(rc_seen - br), 32'(r));
        check({tag, "_done"},   32'(done_seen - bd), 32'(d));
        check({tag, "_error"},  32'(err_seen - be), 32'(e));
        check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = 1'b0;
        n_div     = '0;
        m_div     = '0;
        c_div     = '0;
        repeat (3) tick();
        check("rst_ready",  32'(req_ready),   32'd1);
        check("rst_wr",     32'(write_param), 32'd0);
        check("rst_reconf", 32'(reconfig),    32'd0);
        check("rst_done",   32'(done),        32'd0);
        check("rst_error",  32'(error),       32'd0);
        check("rst_active", 32'(active),      32'd0);
        reset_n = 1'b1;
        repeat (2) tick();

        // Ideal path
        lock_every = 1'b1;
        snap();
        send_req(8'd1, 8'd12, 8'd5, 8'd2, 1, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        check("ideal_active", 32'(active), 32'd1);
        tick();
        check("ideal_ready_fall", 32'(req_ready),   32'd0);
        check("ideal_no_wr_check", 32'(write_param), 32'd0);
        tick();
        check("ideal_first_wr", 32'(write_param), 32'd1);
        check("ideal_first_wr_cyc", 32'(cyc - xfer_cyc), 32'd2);
        wait_end(done_seen + err_seen, 3000);
        check_counts("ideal", 16, 1, 1, 0);

        // Zero divider
        tick();
        snap();
        send_req(8'd4, 8'd4, 8'd4, 8'd0, 0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        tick();
        check("zero_no_wr", 32'(write_param), 32'd0);
        tick();
        check("zero_error", 32'(error), 32'd1);
        check("zero_error_cyc", 32'(cyc - xfer_cyc), 32'd2);
        tick();
        check("zero_ready_after", 32'(req_ready), 32'd1);
        check("zero_error_pulse", 32'(error), 32'd0);
        check_counts("zero", 0, 0, 0, 1);

        // Lock timeout: 1 + MAX_RETRY attempts then error
        lock_every  = 1'b0;
        lock_target = -1;
        snap();
        send_req(8'd2, 8'd3, 8'd4, 8'd5, 4, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        wait_end(done_seen + err_seen, 4000);
        check_counts("timeout", 64, 4, 0, 1);

        // Retry recovery: lock only during the second attempt
        tick();
        lock_target = bm_rc + 2;
        snap();
        send_req(8'd10, 8'd20, 8'd30, 8'd40, 2, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        wait_end(done_seen + err_seen, 4000);
        check_counts("retry", 32, 2, 1, 0);

        // Busy stretch after the third write
        tick();
        lock_every     = 1'b1;
        stretch_target = bm_writes + 3;
        snap();
        send_req(8'd7, 8'd9, 8'd3, 8'd1, 1, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        for (int i = 0; i < 200 && wr_seen < bw + 3; i++) tick();
        t3 = cyc;
        for (int i = 0; i < 400 && wr_seen < bw + 4; i++) tick();
        check("stretch_gap", 32'(cyc - t3), 32'd201);
        check("stretch_after_fall", 32'(cyc - fall_cyc), 32'd1);
        wait_end(done_seen + err_seen, 3000);
        check_counts("stretch", 16, 1, 1, 0);

        // Reset in WWAIT
        tick();
        snap();
        send_req(8'd3, 8'd5, 8'd7, 8'd9, 1, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        for (int i = 0; i < 200 && wr_seen < bw + 2; i++) tick();
        repeat (2) tick();
        reset_n = 1'b0;
        #1;
        check("arst_wr",     32'(write_param), 32'd0);
        check("arst_reconf", 32'(reconfig),    32'd0);
        check("arst_active", 32'(active),      32'd0);
        check("arst_ready",  32'(req_ready),   32'd1);
        exp_q.delete();
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (2) tick();
        check("arst_ready_rel", 32'(req_ready), 32'd1);
        check("arst_no_more_wr", 32'(wr_seen - bw), 32'd2);
        snap();
        send_req(8'd12, 8'd1, 8'd2, 8'd255, 1, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        wait_end(done_seen + err_seen, 3000);
        check_counts("post_rst", 16, 1, 1, 0);

        // req_valid held through a sequence
        tick();
        snap();
        send_req(8'd6, 8'd8, 8'd10, 8'd11, 1, 1'b1, 8'd13, 8'd17, 8'd19, 8'd23);
        repeat (5) tick();
        check("block_ready_low", 32'(req_ready), 32'd0);
        wait_end(done_seen + err_seen, 3000);
        check("block_first_done", 32'(done_seen - bd), 32'd1);
        send_req(8'd13, 8'd17, 8'd19, 8'd23, 1, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        wait_end(done_seen + err_seen, 3000);
        repeat (20) tick();
        check("block_idle_after", 32'(active), 32'd0);
        check_counts("block", 32, 2, 2, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation time exceeded at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
